// File: rtl/alu2_ex_mem_skid_reg.sv
// EX->MEM boundary register for the second (ALU-only) pipe: a 2-entry skid buffer
// with valid/ready on both sides that freezes intake after a faulting instruction.
module alu2_ex_mem_skid_reg #(
    parameter int DATA_W  = 32,
    parameter int EXP_W   = 14,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [RADDR_W-1:0] in_waddr,
    input  logic               in_wen,
    input  logic [DATA_W-1:0]  in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_has_exp,
    output logic [RADDR_W-1:0] out_waddr,
    output logic               out_wen,
    output logic [DATA_W-1:0]  out_pc,
    output logic               exp_hold
);

    // Entry layout, LSB first: result | exp | waddr | wen | pc
    localparam int EXP_LSB   = DATA_W;
    localparam int WADDR_LSB = EXP_LSB + EXP_W;
    localparam int WEN_BIT   = WADDR_LSB + RADDR_W;
    localparam int PC_LSB    = WEN_BIT + 1;
    localparam int ENT_W     = PC_LSB + DATA_W;

    logic [ENT_W-1:0] ent0_q, ent0_d;
    logic [ENT_W-1:0] ent1_q, ent1_d;
    logic [1:0]       count_q, count_d;
    logic             exp_hold_q, exp_hold_d;
    logic [ENT_W-1:0] in_ent;
    logic             push;
    logic             pop;

    assign in_ent    = {in_pc, in_wen, in_waddr, in_exp, in_result};
    assign in_ready  = (count_q < 2'd2) && !exp_hold_q;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        count_d    = count_q;
        exp_hold_d = exp_hold_q;
        if (flush) begin
            // Entry payload is left stale; out_valid gating hides it.
            count_d    = 2'd0;
            exp_hold_d = 1'b0;
        end else begin
            if (push && (|in_exp)) begin
                exp_hold_d = 1'b1;
            end
            case (count_q)
                2'd0: begin
                    if (push) begin
                        ent0_d  = in_ent;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0_d = in_ent;
                    end else if (push) begin
                        ent1_d  = in_ent;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        ent0_d  = ent1_q;
                        count_d = 2'd1;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            count_q    <= 2'd0;
            exp_hold_q <= 1'b0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            count_q    <= count_d;
            exp_hold_q <= exp_hold_d;
        end
    end

    assign out_result  = ent0_q[DATA_W-1:0];
    assign out_exp     = ent0_q[EXP_LSB +: EXP_W];
    assign out_waddr   = ent0_q[WADDR_LSB +: RADDR_W];
    assign out_pc      = ent0_q[PC_LSB +: DATA_W];
    assign out_has_exp = out_valid && (|out_exp);
    assign out_wen     = out_valid && ent0_q[WEN_BIT] && !(|out_exp);
    assign exp_hold    = exp_hold_q;

endmodule

// File: tb/tb_alu2_ex_mem_skid_reg.sv
// Scoreboard bench for alu2_ex_mem_skid_reg: a queue model of the skid buffer
// tracks accepted instructions and the exception freeze.
module tb_alu2_ex_mem_skid_reg;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic [13:0] in_exp = '0;
    logic [4:0]  in_waddr = '0;
    logic        in_wen = 1'b0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [13:0] out_exp;
    logic        out_has_exp;
    logic [4:0]  out_waddr;
    logic        out_wen;
    logic [31:0] out_pc;
    logic        exp_hold;

    typedef struct packed {
        logic [31:0] result;
        logic [13:0] exp;
        logic [4:0]  waddr;
        logic        wen;
        logic [31:0] pc;
    } ent_t;

    ent_t sbq[$];
    bit   m_hold = 1'b0;
    int   vec = 0;
    int   errs = 0;

    alu2_ex_mem_skid_reg #(.DATA_W(32), .EXP_W(14), .RADDR_W(5)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_exp(in_exp), .in_waddr(in_waddr),
        .in_wen(in_wen), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_exp(out_exp), .out_has_exp(out_has_exp),
        .out_waddr(out_waddr), .out_wen(out_wen), .out_pc(out_pc),
        .exp_hold(exp_hold)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return (sbq.size() < 2) && !m_hold;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] r, input logic [13:0] e,
                          input logic [4:0] wa, input logic we);
        in_valid  = v;
        in_result = r;
        in_exp    = e;
        in_waddr  = wa;
        in_wen    = we;
        in_pc     = 32'h0000_1000 + (r << 2);
    endtask

    // Advance one clock, updating the reference model with this cycle's handshakes.
    task automatic step();
        bit   pu;
        bit   po;
        ent_t e;
        pu = in_valid && m_ready();
        po = (sbq.size() != 0) && out_ready;
        if (flush) begin
            sbq.delete();
            m_hold = 1'b0;
        end else begin
            if (po) void'(sbq.pop_front());
            if (pu) begin
                e.result = in_result;
                e.exp    = in_exp;
                e.waddr  = in_waddr;
                e.wen    = in_wen;
                e.pc     = in_pc;
                sbq.push_back(e);
                if (in_exp != 0) m_hold = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vec++;
        if ({out_valid, out_wen, out_has_exp, exp_hold} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_flags: got %b want 0000", {out_valid, out_wen, out_has_exp, exp_hold});
        end
        vec++;
        if (out_result !== 32'h0) begin
            errs++;
            $display("FAIL reset_result: got %h want 0", out_result);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        vec++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        set_in(1'b1, 32'h5, 14'h0, 5'd3, 1'b1);
        step();
        set_in(1'b0, 32'h0, 14'h0, 5'd0, 1'b0);
        vec++;
        if ({out_valid, out_wen, out_has_exp} !== 3'b110) begin
            errs++;
            $display("FAIL single_flags: got %b want 110", {out_valid, out_wen, out_has_exp});
        end
        vec++;
        if (out_result !== 32'h5 || out_waddr !== 5'd3 || out_pc !== 32'h0000_1014) begin
            errs++;
            $display("FAIL single_payload: got %h/%0d/%h want 5/3/00001014", out_result, out_waddr, out_pc);
        end
        step();
        vec++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL single_drain: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_in(1'b1, 32'h10 + i, 14'h0, 5'(i + 8), 1'b1);
            else       set_in(1'b0, 32'h0, 14'h0, 5'd0, 1'b0);
            vec++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            if (i > 0) begin
                vec++;
                if (sbq.size() == 0 || out_valid !== 1'b1 || out_result !== 32'h10 + i - 1 ||
                    out_result !== sbq[0].result || out_waddr !== sbq[0].waddr ||
                    out_pc !== sbq[0].pc || out_wen !== 1'b1) begin
                    errs++;
                    $display("FAIL b2b_out[%0d]: got v=%b r=%h want v=1 r=%h", i, out_valid, out_result, 32'h10 + i - 1);
                end
            end
            step();
        end
        vec++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL b2b_drain: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_r;
        out_ready = 1'b0;
        set_in(1'b1, 32'hA, 14'h0, 5'd10, 1'b1);
        step();
        set_in(1'b1, 32'hB, 14'h0, 5'd11, 1'b0);
        step();
        set_in(1'b0, 32'h0, 14'h0, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'hA || out_pc !== sbq[0].pc) begin
                errs++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b r=%h want rdy=0 v=1 r=a", i, in_ready, out_valid, out_result);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_r = 32'hA + i;
            vec++;
            if (sbq.size() == 0 || out_valid !== 1'b1 || out_result !== exp_r ||
                out_result !== sbq[0].result || out_wen !== sbq[0].wen || out_waddr !== sbq[0].waddr) begin
                errs++;
                $display("FAIL stall_pop[%0d]: got v=%b r=%h wen=%b want v=1 r=%h", i, out_valid, out_result, out_wen, exp_r);
            end
            step();
            vec++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL stall_ready[%0d]: got %b want 1", i, in_ready);
            end
        end
        vec++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL stall_drain: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_exception();
        out_ready = 1'b1;
        set_in(1'b1, 32'h77, 14'h0002, 5'd7, 1'b1);
        step();
        set_in(1'b0, 32'h0, 14'h0, 5'd0, 1'b0);
        vec++;
        if ({out_valid, out_has_exp, out_wen, exp_hold, in_ready} !== 5'b11010 || out_exp !== 14'h0002) begin
            errs++;
            $display("FAIL exc_head: got v,hx,wen,hold,rdy=%b exp=%h want 11010 exp=0002",
                     {out_valid, out_has_exp, out_wen, exp_hold, in_ready}, out_exp);
        end
        set_in(1'b1, 32'h99, 14'h0, 5'd9, 1'b1);
        step();
        step();
        set_in(1'b0, 32'h0, 14'h0, 5'd0, 1'b0);
        vec++;
        if ({out_valid, out_has_exp, out_wen, exp_hold, in_ready} !== 5'b00010) begin
            errs++;
            $display("FAIL exc_frozen: got v,hx,wen,hold,rdy=%b want 00010",
                     {out_valid, out_has_exp, out_wen, exp_hold, in_ready});
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vec++;
        if (exp_hold !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL exc_flush: got hold=%b rdy=%b v=%b want 0 1 0", exp_hold, in_ready, out_valid);
        end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        set_in(1'b1, 32'h21, 14'h0, 5'd1, 1'b1);
        step();
        set_in(1'b1, 32'h22, 14'h0, 5'd2, 1'b1);
        step();
        set_in(1'b1, 32'h23, 14'h0, 5'd3, 1'b1);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 14'h0, 5'd0, 1'b0);
        vec++;
        if ({out_valid, out_wen, out_has_exp, in_ready} !== 4'b0001) begin
            errs++;
            $display("FAIL flush_full: got v,wen,hx,rdy=%b want 0001", {out_valid, out_wen, out_has_exp, in_ready});
        end
        step();
        vec++;
        if (out_valid !== 1'b0 || sbq.size() != 0) begin
            errs++;
            $display("FAIL flush_not_captured: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'h55, 14'h0, 5'd5, 1'b1);
        step();
        set_in(1'b0, 32'h0, 14'h0, 5'd0, 1'b0);
        vec++;
        if (out_valid !== 1'b1 || out_result !== 32'h55) begin
            errs++;
            $display("FAIL areset_pre: got v=%b r=%h want 1 55", out_valid, out_result);
        end
        #2;
        resetn = 1'b0;
        sbq.delete();
        m_hold = 1'b0;
        #1;
        vec++;
        if (out_valid !== 1'b0 || out_wen !== 1'b0) begin
            errs++;
            $display("FAIL areset_immediate: got v=%b wen=%b want 0 0", out_valid, out_wen);
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;
        #1;
        vec++;
        if (in_ready !== 1'b1 || out_result !== 32'h0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL areset_release: got rdy=%b r=%h v=%b want 1 0 0", in_ready, out_result, out_valid);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        set_in(1'b1, 32'h66, 14'h0, 5'd6, 1'b1);
        step();
        set_in(1'b0, 32'h0, 14'h0, 5'd0, 1'b0);
        vec++;
        if (sbq.size() == 0 || out_valid !== 1'b1 || out_result !== 32'h66 || out_result !== sbq[0].result) begin
            errs++;
            $display("FAIL areset_resume: got v=%b r=%h want 1 66", out_valid, out_result);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_exception();
        test_flush_full();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/alu2_ex_mem_skid_reg.md
Name: alu2_ex_mem_skid_reg

Overview:
- Registered EX→MEM boundary for the second (ALU-only) pipeline.
- Captures the second-pipe ALU result, its 14-bit exception vector, destination register and PC into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Freezes intake after a faulting instruction until the pipeline is flushed.
- Sits directly downstream of the second-pipe ALU and feeds the MEM/commit stage.

Parameters:
- DATA_W, 32, width of ALU result and PC fields
- EXP_W, 14, width of exception vector (bit 1 = arithmetic overflow)
- RADDR_W, 5, destination register index width

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush (exception/branch recovery)
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  block accepts upstream instruction this cycle
- in_result  in  DATA_W  ALU Out
- in_exp  in  EXP_W  ALU Exp_Second_new
- in_waddr  in  RADDR_W  destination register
- in_wen  in  1  register write request
- in_pc  in  DATA_W  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- out_result  out  DATA_W  head result
- out_exp  out  EXP_W  head exception vector
- out_has_exp  out  1  OR-reduction of out_exp, qualified by out_valid
- out_waddr  out  RADDR_W  head destination
- out_wen  out  1  head write enable; 0 if head exp nonzero or out_valid=0
- out_pc  out  DATA_W  head PC
- exp_hold  out  1  faulting instruction accepted, intake frozen

Behaviour:
- State: entry0 (head), entry1 (skid), count ∈ {0,1,2}, exp_hold.
- Reset (resetn=0, async): count=0, exp_hold=0, all entry fields 0. All outputs 0: out_valid, out_has_exp, out_wen=0; in_ready=1 after release.
- in_ready = (count<2) && !exp_hold. Combinational from registered state only; never depends on out_ready or in_valid.
- push = in_valid && in_ready.
- pop = out_valid && out_ready.
- out_valid = (count!=0). Out fields are driven from entry0, registered, so there is no combinational in→out path.
- Latency: pushed instruction appears on outputs the next cycle. Sustained throughput is 1/cycle while out_ready=1.
- Transitions when flush=0:
  - count0: push → entry0, count1.
  - count1, push only: write entry1, count2.
  - count1, pop only: count0.
  - count1, push+pop: entry0 ← input, count1.
  - count2, pop: entry0 ← entry1, count1. No push is possible at count2.
- Payload is stable while out_valid=1 and out_ready=0.
- exp_hold: set on the cycle an instruction with nonzero in_exp is pushed. It stays set while that instruction drains and is cleared only by flush or reset.
- Bits of in_exp pass unmodified. in_wen is stored as given; gating is applied at output: out_wen = out_valid && entry0.wen && ~|entry0.exp.
- flush=1 (highest priority after reset): next cycle count=0, exp_hold=0; any same-cycle push or pop is discarded. Entry data need not be cleared, but out_valid, out_wen and out_has_exp read 0.
- Reset asserted mid-transfer: all state is cleared immediately. No partial entry survives.
- out_has_exp and out_wen are 0 whenever out_valid=0, regardless of stale data.

Test Plan:
- Reset then single push (result=0x0000_0005, waddr=3, wen=1, exp=0) with out_ready=1:
  - out_valid=1 next cycle, out_result=5, out_wen=1.
  - Following cycle out_valid=0.
- Back-to-back pushes of 0x10, 0x11, 0x12 with out_ready=1:
  - Outputs 0x10, 0x11, 0x12 on consecutive cycles.
  - in_ready stays 1 throughout.
- out_ready=0 and pushes 0xA, 0xB:
  - count=2, in_ready=0, out_result holds 0xA.
  - Raise out_ready: 0xA then 0xB emerge, in_ready returns 1 after the first pop.
- Push with in_exp=14'h0002 (overflow), wen=1:
  - out_has_exp=1, out_wen=0.
  - exp_hold=1 and in_ready=0 even after the entry drains.
  - Assert flush: exp_hold=0, in_ready=1 next cycle.
- count=2 with flush=1 and in_valid=1 in the same cycle:
  - Next cycle out_valid=0, count=0; the offered instruction is not captured.
- resetn low for one cycle while count=1:
  - out_valid=0 immediately (async).
  - After release in_ready=1, out_result=0.
